// File: rtl/dynamics_ctrl.sv
// dynamics_ctrl: sequencing and gain control for the dynamics stage.
// Accepts one sample per handshake, measures its level (count of significant
// magnitude bits), tracks a peak envelope with slow release, and drives the
// gain word toward a threshold-dependent target.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   sample_valid  sample strobe, taken only while idle
//   sample_in     signed 16-bit sample
//   threshold     compression threshold level (0..16), captured at accept
//   busy          high while a sample is being processed
//   curr          envelope level presented to the dynamics stage
//   start         threshold of the sample that produced this update
//   multiple      gain word, Q1.7
//   gain_valid    one-cycle pulse when curr/start/multiple update
module dynamics_ctrl #(
  parameter int ATTACK_STEP = 8,
  parameter int RELEASE_DIV = 64,
  parameter int GAIN_UNITY  = 128,
  parameter int GAIN_FLOOR  = 16,
  parameter int GAIN_SLOPE  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] sample_in,
  input  logic [4:0]  threshold,
  output logic        busy,
  output logic [4:0]  curr,
  output logic [4:0]  start,
  output logic [7:0]  multiple,
  output logic        gain_valid
);

  localparam int CNT_W = (RELEASE_DIV > 1) ? $clog2(RELEASE_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LEVEL, S_ENV, S_GAIN} state_t;

  // Captured request: saturated magnitude plus the threshold in force for it.
  typedef struct packed {
    logic [14:0] mag;
    logic [4:0]  thr;
  } req_t;

  state_t             state_q, state_d;
  req_t               req_q, req_d;
  logic [3:0]         level_q, level_d;
  logic [3:0]         env_q, env_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         curr_q, curr_d;
  logic [4:0]         start_q, start_d;
  logic [7:0]         mult_q, mult_d;
  logic               gv_q, gv_d;
  logic               busy_q, busy_d;

  logic [14:0]        mag_in;
  logic [3:0]         level_calc;
  logic [8:0]         target;
  logic [7:0]         mult_nxt;

  // |sample_in|; -32768 has no positive counterpart and saturates.
  always_comb begin
    mag_in = sample_in[14:0];
    if (sample_in[15]) begin
      if (sample_in == 16'h8000) mag_in = 15'h7fff;
      else                       mag_in = 15'(~sample_in + 16'd1);
    end
  end

  // Position of the highest set bit, 1-based; 0 for a zero magnitude.
  always_comb begin
    level_calc = '0;
    for (int i = 0; i < 15; i++)
      if (req_q.mag[i]) level_calc = 4'(i + 1);
  end

  // Target gain from the (already updated) envelope. The reduction is kept
  // wide and compared against the headroom so the subtraction never wraps.
  always_comb begin
    logic [4:0]  diff;
    logic [15:0] red;
    diff   = '0;
    red    = '0;
    target = 9'(GAIN_UNITY);
    if ({1'b0, env_q} > req_q.thr) begin
      diff = {1'b0, env_q} - req_q.thr;
      red  = 16'(GAIN_SLOPE) * {11'd0, diff};
      if (red >= 16'(GAIN_UNITY - GAIN_FLOOR)) target = 9'(GAIN_FLOOR);
      else                                     target = 9'(16'(GAIN_UNITY) - red);
    end
  end

  // Fast attack (clamped at target), one-code-per-sample release.
  always_comb begin
    logic [8:0] m;
    m        = {1'b0, mult_q};
    mult_nxt = mult_q;
    if (m > target) begin
      if (m < target + 9'(ATTACK_STEP)) mult_nxt = target[7:0];
      else                              mult_nxt = 8'(m - 9'(ATTACK_STEP));
    end else if (m < target) begin
      mult_nxt = mult_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    level_d = level_q;
    env_d   = env_q;
    cnt_d   = cnt_q;
    curr_d  = curr_q;
    start_d = start_q;
    mult_d  = mult_q;
    gv_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          req_d.mag = mag_in;
          req_d.thr = threshold;
          state_d   = S_LEVEL;
        end
      end
      S_LEVEL: begin
        level_d = level_calc;
        state_d = S_ENV;
      end
      S_ENV: begin
        // A new peak takes priority over a pending decay step.
        if (level_q >= env_q) begin
          env_d = level_q;
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(RELEASE_DIV - 1)) begin
          cnt_d = '0;
          env_d = env_q - 4'd1;  // env_q > level_q >= 0, so no underflow
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        state_d = S_GAIN;
      end
      S_GAIN: begin
        mult_d  = mult_nxt;
        curr_d  = {1'b0, env_q};
        start_d = req_q.thr;
        gv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      level_q <= '0;
      env_q   <= '0;
      cnt_q   <= '0;
      curr_q  <= '0;
      start_q <= '0;
      mult_q  <= 8'(GAIN_UNITY);
      gv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      level_q <= level_d;
      env_q   <= env_d;
      cnt_q   <= cnt_d;
      curr_q  <= curr_d;
      start_q <= start_d;
      mult_q  <= mult_d;
      gv_q    <= gv_d;
      busy_q  <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign curr       = curr_q;
  assign start      = start_q;
  assign multiple   = mult_q;
  assign gain_valid = gv_q;

endmodule

// File: tb/tb_dynamics_ctrl.sv
module tb_dynamics_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic [4:0]  threshold;
  logic        busy;
  logic [4:0]  curr;
  logic [4:0]  start;
  logic [7:0]  multiple;
  logic        gain_valid;

  int errors = 0;
  int checks = 0;

  // Reference state, kept as plain integers.
  int m_env  = 0;
  int m_cnt  = 0;
  int m_mult = 128;

  dynamics_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_in   (sample_in),
    .threshold   (threshold),
    .busy        (busy),
    .curr        (curr),
    .start       (start),
    .multiple    (multiple),
    .gain_valid  (gain_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_env  = 0;
    m_cnt  = 0;
    m_mult = 128;
  endtask

  // One accepted sample, from the behavioural rules with default parameters.
  task automatic model_step(input logic [15:0] s, input int thr);
    int v, lvl, tgt;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    lvl = 0;
    while ((1 << lvl) <= v) lvl++;
    if (lvl >= m_env) begin
      m_env = lvl;
      m_cnt = 0;
    end else if (m_cnt == 63) begin
      m_cnt = 0;
      m_env = m_env - 1;
    end else begin
      m_cnt++;
    end
    if (m_env <= thr) tgt = 128;
    else              tgt = 128 - 16 * (m_env - thr);
    if (tgt < 16) tgt = 16;
    if (m_mult > tgt)      m_mult = (m_mult - 8 < tgt) ? tgt : m_mult - 8;
    else if (m_mult < tgt) m_mult = m_mult + 1;
  endtask

  // Present one sample from idle, then check latency and the update.
  task automatic do_sample(input logic [15:0] s, input int thr);
    int lat;
    lat = 0;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = s;
    threshold    = 5'(thr);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    model_step(s, thr);
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (gain_valid) lat = k;
    end
    chk("latency", lat, 3);
    chk("curr", int'(curr), m_env);
    chk("start", int'(start), thr);
    chk("multiple", int'(multiple), m_mult);
  endtask

  initial begin
    int gv_cnt, first_e, last_e;
    logic signed [15:0] rs;

    rst = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    threshold = '0;

    // Reset values, during and after reset with no stimulus.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_multiple", int'(multiple), 128);
    chk("rst_curr", int'(curr), 0);
    chk("rst_start", int'(start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gv", int'(gain_valid), 0);
    @(negedge clk) rst = 1'b1;
    gv_cnt = 0;
    repeat (10) begin @(posedge clk); #1; if (gain_valid) gv_cnt++; end
    chk("idle_no_gv", gv_cnt, 0);
    chk("idle_multiple", int'(multiple), 128);

    // Attack toward target 80 with threshold 10.
    do_sample(16'h1555, 10);
    chk("first_mult_120", int'(multiple), 120);
    chk("first_curr_13", int'(curr), 13);
    repeat (9) do_sample(16'h1555, 10);
    chk("hold_80", int'(multiple), 80);

    // Slow release: env drops on the 64th quiet sample.
    repeat (63) do_sample(16'h0000, 10);
    chk("pre_decay_curr", int'(curr), 13);
    do_sample(16'h0000, 10);
    chk("decay_curr_12", int'(curr), 12);
    chk("decay_mult_81", int'(multiple), 81);
    repeat (20) do_sample(16'h0000, 10);
    chk("release_bound_96", int'(multiple), 96);

    // Full-scale negative with threshold 0: clamp at the floor.
    do_sample(16'h8000, 0);
    chk("fs_curr_15", int'(curr), 15);
    repeat (15) do_sample(16'h8000, 0);
    chk("floor_16", int'(multiple), 16);

    // Randomized samples across levels and thresholds.
    for (int n = 0; n < 60; n++) begin
      rs = $signed(16'($urandom)) >>> $urandom_range(0, 15);
      if ((n % 7) == 3) rs = '0;
      do_sample(16'(rs), int'($urandom_range(0, 16)));
    end

    // A strobe while busy is dropped.
    @(negedge clk);
    sample_valid = 1'b1; sample_in = 16'h0100; threshold = 5'd2;
    @(posedge clk); #1;
    chk("busy_after_accept", int'(busy), 1);
    model_step(16'h0100, 2);
    @(negedge clk);
    sample_in = 16'h7fff; threshold = 5'd0;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    gv_cnt = 0;
    repeat (10) begin @(posedge clk); #1; if (gain_valid) gv_cnt++; end
    chk("drop_one_gv", gv_cnt, 1);
    chk("drop_curr", int'(curr), m_env);
    chk("drop_start", int'(start), 2);
    chk("drop_multiple", int'(multiple), m_mult);

    // Held strobe: one update every 4 cycles.
    @(negedge clk);
    sample_valid = 1'b1; sample_in = 16'h0f00; threshold = 5'd4;
    gv_cnt = 0; first_e = 0; last_e = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (gain_valid) begin
        gv_cnt++;
        if (first_e == 0) first_e = e;
        else chk("held_spacing", e - last_e, 4);
        last_e = e;
      end
    end
    @(negedge clk) sample_valid = 1'b0;
    repeat (5) model_step(16'h0f00, 4);
    chk("held_first", first_e, 4);
    chk("held_count", gv_cnt, 5);
    chk("held_multiple", int'(multiple), m_mult);

    // Reset during ENV aborts the sample.
    @(negedge clk);
    sample_valid = 1'b1; sample_in = 16'h7fff; threshold = 5'd3;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_curr", int'(curr), 0);
    chk("abort_start", int'(start), 0);
    chk("abort_multiple", int'(multiple), 128);
    chk("abort_gv", int'(gain_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    gv_cnt = 0;
    repeat (6) begin @(posedge clk); #1; if (gain_valid) gv_cnt++; end
    chk("abort_no_gv", gv_cnt, 0);
    model_reset();
    do_sample(16'h1555, 10);
    chk("post_reset_120", int'(multiple), 120);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
